// File: rtl/rx_hsk_fifo_if.sv
// ============================================================================
// Module      : rx_hsk_fifo_if
// Description : Bundle of the upstream 4-phase handshake, FT245 read-permission
//               and downstream pop/data signals of rx_hsk_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_hsk_fifo_if #(
    parameter int RXF_DEPTH_LOG2 = 4,
    parameter int RXF_DATA_BITS  = 8
);
    logic                       in_hsk_req;
    logic [RXF_DATA_BITS-1:0]   in_hsk_data;
    logic                       out_hsk_ack;
    logic                       out_rx_enable;
    logic [RXF_DATA_BITS-1:0]   out_data;
    logic                       out_valid;
    logic                       in_pop;
    logic [RXF_DEPTH_LOG2:0]    out_level;

    // FIFO side: receives requests and pops, drives ack, data and status.
    modport slave (
        input  in_hsk_req,
        input  in_hsk_data,
        input  in_pop,
        output out_hsk_ack,
        output out_rx_enable,
        output out_data,
        output out_valid,
        output out_level
    );

    // Environment side: upstream controller plus downstream consumer.
    modport master (
        output in_hsk_req,
        output in_hsk_data,
        output in_pop,
        input  out_hsk_ack,
        input  out_rx_enable,
        input  out_data,
        input  out_valid,
        input  out_level
    );
endinterface

`default_nettype wire

// File: rtl/rx_hsk_fifo.sv
// ============================================================================
// Module      : rx_hsk_fifo
// Description : Receive FIFO fed by a 4-phase req/ack handshake from the FT245
//               controller RX side. One byte is written per handshake cycle;
//               a full FIFO back-pressures by withholding ack. The head byte,
//               valid flag, level and FT245 read permission are registered.
//               Optional macro RX_HSK_FIFO_REQ_SYNC_EN inserts a 2-flop
//               synchronizer on the request before the handshake FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_hsk_fifo #(
    parameter int RXF_DEPTH_LOG2 = 4,
    parameter int RXF_DATA_BITS  = 8,
    parameter int RXF_AF_MARGIN  = 2
) (
    input  wire logic       in_clk,
    input  wire logic       in_rst,
    rx_hsk_fifo_if.slave    bus
);

    localparam int                      DEPTH      = 1 << RXF_DEPTH_LOG2;
    localparam int                      AF_LIMIT   = DEPTH - RXF_AF_MARGIN;
    localparam logic [RXF_DEPTH_LOG2:0] c_DEPTH    = DEPTH[RXF_DEPTH_LOG2:0];
    localparam logic [RXF_DEPTH_LOG2:0] c_AF_LIMIT = AF_LIMIT[RXF_DEPTH_LOG2:0];

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_ACK  = 1'b1;

    logic [RXF_DATA_BITS-1:0]   r_mem [DEPTH];
    logic [0:0]                 r_state;
    logic                       r_ack;
    logic [RXF_DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [RXF_DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [RXF_DEPTH_LOG2:0]    r_level;
    logic                       r_valid;
    logic [RXF_DATA_BITS-1:0]   r_data;
    logic                       r_rx_enable;

    logic                       w_req;
    logic                       w_full;
    logic                       w_wr;
    logic                       w_rd;
    logic [RXF_DEPTH_LOG2-1:0]  w_wr_ptr_nxt;
    logic [RXF_DEPTH_LOG2-1:0]  w_rd_ptr_nxt;
    logic [RXF_DEPTH_LOG2:0]    w_level_nxt;
    logic [RXF_DATA_BITS-1:0]   w_head_nxt;

`ifdef RX_HSK_FIFO_REQ_SYNC_EN
    logic r_req_s1;
    logic r_req_s2;

    // Two-flop synchronizer for the asynchronous upstream request.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
        end else begin
            r_req_s1 <= bus.in_hsk_req;
            r_req_s2 <= r_req_s1;
        end
    end

    assign w_req = r_req_s2;
`else
    assign w_req = bus.in_hsk_req;
`endif

    // Full is judged on the pre-edge level, so a write blocked while a pop
    // happens is simply retried on the following edge (req is still high).
    assign w_full = (r_level == c_DEPTH);
    assign w_wr   = (r_state == c_ST_IDLE) && w_req && !w_full;
    assign w_rd   = bus.in_pop && r_valid;

    assign w_wr_ptr_nxt = w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;

    // Next level and next head byte; a write landing on the next read slot
    // only happens when the FIFO would otherwise be empty, so the incoming
    // byte becomes the registered head directly.
    always_comb begin
        w_level_nxt = r_level;
        if (w_wr && !w_rd) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_wr && w_rd) begin
            w_level_nxt = r_level - 1'b1;
        end
        w_head_nxt = r_mem[w_rd_ptr_nxt];
        if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = bus.in_hsk_data;
        end
    end

    // Handshake FSM: one write on entry to ACK, return to IDLE once req drops.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= c_ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_wr) begin
                        r_state <= c_ST_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                default: begin
                    if (!w_req) begin
                        r_state <= c_ST_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge in_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.in_hsk_data;
        end
    end

    // Pointers, level and registered head/status outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_rx_enable <= 1'b1;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_valid     <= (w_level_nxt != '0);
            r_data      <= w_head_nxt;
            r_rx_enable <= (w_level_nxt <= c_AF_LIMIT);
        end
    end

    assign bus.out_hsk_ack   = r_ack;
    assign bus.out_rx_enable = r_rx_enable;
    assign bus.out_data      = r_data;
    assign bus.out_valid     = r_valid;
    assign bus.out_level     = r_level;

endmodule

`default_nettype wire
